peripheral_hub: RTL and testbench

- Shared peripheral link for multi-core BRISC-V project tops; sits between NUM_CORES RISC_V_Core instances and one external peripheral channel.
- Outbound: buffers each core's to_peripheral traffic in a per-core FIFO, round-robin arbitrates, and presents it on a single ready/valid port tagged with the core ID.
- Inbound: routes tagged peripheral responses back to the addressed core.

---
 rtl/briscv_hub_pkg.sv | 27 ++
 rtl/hub_fifo.sv | 54 +++++
 rtl/peripheral_hub.sv | 163 ++++++++++++++++
 tb/tb_peripheral_hub.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/briscv_hub_pkg.sv
// Shared definitions for the multi-core peripheral hub: command codes,
// output-stage state encoding and a constant-friendly clog2.
package briscv_hub_pkg;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_CTRL  = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hub_fifo.sv
// Single-clock FIFO used as the per-core outbound buffer. Push while full and
// pop while empty are ignored internally, so callers may drive raw strobes.
module hub_fifo
    import briscv_hub_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/peripheral_hub.sv
// Multi-core peripheral link: per-core outbound FIFOs, round-robin output stage,
// registered inbound demux. Optional counters under PERIPHERAL_HUB_STATS_EN.
module peripheral_hub
    import briscv_hub_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int CMD_BITS     = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int CORE_ID_BITS = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             core_out_valid,
    input  logic [NUM_CORES*CMD_BITS-1:0]    core_out_cmd,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_out_data,
    output logic [NUM_CORES-1:0]             core_out_full,
    output logic [NUM_CORES-1:0]             core_out_overflow,
    output logic                             ext_out_valid,
    input  logic                             ext_out_ready,
    output logic [CMD_BITS-1:0]              ext_out_cmd,
    output logic [DATA_WIDTH-1:0]            ext_out_data,
    output logic [CORE_ID_BITS-1:0]          ext_out_core_id,
    input  logic                             ext_in_valid,
    input  logic [CORE_ID_BITS-1:0]          ext_in_core_id,
    input  logic [CMD_BITS-1:0]              ext_in_cmd,
    input  logic [DATA_WIDTH-1:0]            ext_in_data,
    output logic [NUM_CORES-1:0]             core_in_valid,
    output logic [CMD_BITS-1:0]              core_in_cmd,
    output logic [DATA_WIDTH-1:0]            core_in_data
`ifdef PERIPHERAL_HUB_STATS_EN
    ,
    output logic [NUM_CORES*16-1:0]          stat_fwd_count,
    output logic [NUM_CORES*8-1:0]           stat_drop_count
`endif
);

    localparam int ENTRY_W = CMD_BITS + DATA_WIDTH;

    logic [NUM_CORES-1:0]              fifo_full;
    logic [NUM_CORES-1:0]              fifo_empty;
    logic [NUM_CORES-1:0]              fifo_pop;
    logic [NUM_CORES-1:0][ENTRY_W-1:0] fifo_rdata;

    out_state_t                state;
    out_state_t                state_next;
    logic                      load;
    logic                      any_ready;
    logic [CORE_ID_BITS-1:0]   sel;
    logic [CORE_ID_BITS-1:0]   last_grant;
    logic [ENTRY_W-1:0]        sel_entry;
    int                        best_dist;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_fifo
        hub_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (core_out_valid[g]),
            .pop   (fifo_pop[g]),
            .wdata ({core_out_cmd[g*CMD_BITS +: CMD_BITS], core_out_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    assign core_out_full = fifo_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) core_out_overflow <= '0;
        else        core_out_overflow <= core_out_overflow | (core_out_valid & fifo_full);
    end

    // Round-robin pick: smallest rotation distance from the last grant wins.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        best_dist = NUM_CORES;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!fifo_empty[i] &&
                ((i + NUM_CORES - 1 - int'(last_grant)) % NUM_CORES) < best_dist) begin
                best_dist = (i + NUM_CORES - 1 - int'(last_grant)) % NUM_CORES;
                sel       = CORE_ID_BITS'(i);
                any_ready = 1'b1;
            end
        end
    end

    always_comb begin
        sel_entry = '0;
        fifo_pop  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel == CORE_ID_BITS'(i)) begin
                sel_entry   = fifo_rdata[i];
                fifo_pop[i] = load && any_ready;
            end
        end
    end

    assign load = (state == ST_EMPTY) || ext_out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load) state_next = any_ready ? ST_HOLD : ST_EMPTY;
    end

    always_comb begin
        ext_out_valid = (state == ST_HOLD);
    end

    // Output-stage payload and grant pointer advance only on a load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_out_cmd     <= '0;
            ext_out_data    <= '0;
            ext_out_core_id <= '0;
            last_grant      <= CORE_ID_BITS'(NUM_CORES - 1);
        end else if (load && any_ready) begin
            ext_out_cmd     <= sel_entry[ENTRY_W-1 -: CMD_BITS];
            ext_out_data    <= sel_entry[DATA_WIDTH-1:0];
            ext_out_core_id <= sel;
            last_grant      <= sel;
        end
    end

    // Inbound: one-cycle registered demux; out-of-range tags are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_in_valid <= '0;
            core_in_cmd   <= '0;
            core_in_data  <= '0;
        end else begin
            core_in_valid <= '0;
            if (ext_in_valid && (int'(ext_in_core_id) < NUM_CORES)) begin
                core_in_valid <= {{(NUM_CORES-1){1'b0}}, 1'b1} << ext_in_core_id;
                core_in_cmd   <= ext_in_cmd;
                core_in_data  <= ext_in_data;
            end
        end
    end

`ifdef PERIPHERAL_HUB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_fwd_count  <= '0;
            stat_drop_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (ext_out_valid && ext_out_ready && ext_out_core_id == CORE_ID_BITS'(i))
                    stat_fwd_count[i*16 +: 16] <= stat_fwd_count[i*16 +: 16] + 16'd1;
                if (core_out_valid[i] && fifo_full[i] && stat_drop_count[i*8 +: 8] != 8'hFF)
                    stat_drop_count[i*8 +: 8] <= stat_drop_count[i*8 +: 8] + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_peripheral_hub.sv
// Scoreboard bench for peripheral_hub (4 cores, 3-bit core tags so an
// out-of-range inbound tag can be exercised).
module tb_peripheral_hub;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int CB = 2;
    localparam int FD = 4;
    localparam int IB = 3;

    typedef struct packed {
        logic [IB-1:0] id;
        logic [CB-1:0] cmd;
        logic [DW-1:0] data;
    } ent_t;

    logic              clock;
    logic              reset;
    logic [NC-1:0]     core_out_valid;
    logic [NC*CB-1:0]  core_out_cmd;
    logic [NC*DW-1:0]  core_out_data;
    logic [NC-1:0]     core_out_full;
    logic [NC-1:0]     core_out_overflow;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [CB-1:0]     ext_out_cmd;
    logic [DW-1:0]     ext_out_data;
    logic [IB-1:0]     ext_out_core_id;
    logic              ext_in_valid;
    logic [IB-1:0]     ext_in_core_id;
    logic [CB-1:0]     ext_in_cmd;
    logic [DW-1:0]     ext_in_data;
    logic [NC-1:0]     core_in_valid;
    logic [CB-1:0]     core_in_cmd;
    logic [DW-1:0]     core_in_data;
`ifdef PERIPHERAL_HUB_STATS_EN
    logic [NC*16-1:0]  stat_fwd_count;
    logic [NC*8-1:0]   stat_drop_count;
`endif

    ent_t out_q[$];
    ent_t in_q[$];
    int   total = 0;
    int   bad   = 0;

    peripheral_hub #(
        .NUM_CORES(NC), .DATA_WIDTH(DW), .CMD_BITS(CB), .FIFO_DEPTH(FD), .CORE_ID_BITS(IB)
    ) dut (
        .clock(clock), .reset(reset),
        .core_out_valid(core_out_valid), .core_out_cmd(core_out_cmd),
        .core_out_data(core_out_data), .core_out_full(core_out_full),
        .core_out_overflow(core_out_overflow),
        .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .ext_out_cmd(ext_out_cmd), .ext_out_data(ext_out_data),
        .ext_out_core_id(ext_out_core_id),
        .ext_in_valid(ext_in_valid), .ext_in_core_id(ext_in_core_id),
        .ext_in_cmd(ext_in_cmd), .ext_in_data(ext_in_data),
        .core_in_valid(core_in_valid), .core_in_cmd(core_in_cmd),
        .core_in_data(core_in_data)
`ifdef PERIPHERAL_HUB_STATS_EN
        , .stat_fwd_count(stat_fwd_count), .stat_drop_count(stat_drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_push(input int c, input logic [CB-1:0] cmd, input logic [DW-1:0] data);
        core_out_valid[c]       = 1'b1;
        core_out_cmd[c*CB +: CB] = cmd;
        core_out_data[c*DW +: DW] = data;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        core_out_valid = '0;
        ext_in_valid   = 1'b0;
        ext_out_ready  = 1'b0;
        out_q.delete();
        in_q.delete();
        step();
        step();
        reset = 1'b1;
    endtask

    // Monitor: pops expected entries whenever the DUT presents a transfer.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (reset && ext_out_valid && ext_out_ready) begin
                if (out_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got id=%0d data=%h required no transfer",
                             ext_out_core_id, ext_out_data);
                end else begin
                    e = out_q.pop_front();
                    chk("out_id", 64'(ext_out_core_id), 64'(e.id));
                    chk("out_cmd", 64'(ext_out_cmd), 64'(e.cmd));
                    chk("out_data", 64'(ext_out_data), 64'(e.data));
                end
            end
            if (reset && core_in_valid != '0) begin
                if (in_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_in: got valid=%b required none", core_in_valid);
                end else begin
                    e = in_q.pop_front();
                    chk("in_valid", 64'(core_in_valid), 64'(1) << e.id);
                    chk("in_cmd", 64'(core_in_cmd), 64'(e.cmd));
                    chk("in_data", 64'(core_in_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        core_out_valid = '0; core_out_cmd = '0; core_out_data = '0;
        ext_out_ready = 1'b0;
        ext_in_valid = 1'b0; ext_in_core_id = '0; ext_in_cmd = '0; ext_in_data = '0;
        step(); step();
        chk("rst_full", 64'(core_out_full), 0);
        chk("rst_ovf", 64'(core_out_overflow), 0);
        chk("rst_valid", 64'(ext_out_valid), 0);
        chk("rst_payload", {ext_out_core_id, ext_out_cmd, ext_out_data}, 0);
        chk("rst_in", {core_in_valid, core_in_cmd, core_in_data}, 0);
        reset = 1'b1;

        // Latency, hold under backpressure, release.
        repeat (7) step();
        chk("t1_idle", 64'(ext_out_valid), 0);
        drive_push(2, 2'd1, 32'hDEADBEEF);
        out_q.push_back('{id: 3'd2, cmd: 2'd1, data: 32'hDEADBEEF});
        step();
        core_out_valid = '0;
        chk("t1_n1", 64'(ext_out_valid), 0);
        step();
        chk("t1_n2", 64'(ext_out_valid), 1);
        chk("t1_id", 64'(ext_out_core_id), 2);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t1_hold", {ext_out_valid, ext_out_data}, {1'b1, 32'hDEADBEEF});
        end
        ext_out_ready = 1'b1;
        step();
        chk("t1_drop", 64'(ext_out_valid), 0);

        // Fairness: four cores, three entries each, back to back.
        do_reset();
        ext_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NC; c++) begin
                drive_push(c, CB'(c + k), 32'hC000_0000 | (c << 8) | k);
                out_q.push_back('{id: IB'(c), cmd: CB'(c + k), data: 32'hC000_0000 | (c << 8) | k});
            end
            step();
        end
        core_out_valid = '0;
        chk("t2_stream", 64'(ext_out_valid), 1);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("t2_stream", 64'(ext_out_valid), 1);
        end
        step();
        chk("t2_end", 64'(ext_out_valid), 0);

        // Fill core 1 under backpressure: one entry sits in the output stage,
        // FIFO_DEPTH more in the FIFO, the sixth push is dropped.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drive_push(1, 2'd1, 32'hA100_0000 + n);
            if (n < 5) out_q.push_back('{id: 3'd1, cmd: 2'd1, data: 32'hA100_0000 + n});
            step();
            if (n == 3) chk("t3_notfull", 64'(core_out_full[1]), 0);
            if (n == 4) chk("t3_full", 64'(core_out_full), 4'b0010);
            if (n == 4) chk("t3_noovf", 64'(core_out_overflow), 0);
        end
        core_out_valid = '0;
        chk("t3_ovf", 64'(core_out_overflow), 4'b0010);
`ifdef PERIPHERAL_HUB_STATS_EN
        chk("t3_drop_cnt", 64'(stat_drop_count[15:8]), 1);
`endif
        ext_out_ready = 1'b1;
        repeat (7) step();
        ext_out_ready = 1'b0;
        chk("t3_drained", {ext_out_valid, core_out_full}, 0);
`ifdef PERIPHERAL_HUB_STATS_EN
        chk("t3_fwd_cnt", 64'(stat_fwd_count[31:16]), 5);
`endif

        // Inbound routing, in-range and out-of-range tags.
        ext_in_valid = 1'b1; ext_in_core_id = 3'd3; ext_in_cmd = 2'd2; ext_in_data = 32'h12345678;
        in_q.push_back('{id: 3'd3, cmd: 2'd2, data: 32'h12345678});
        step();
        ext_in_valid = 1'b0;
        chk("t4_pulse", 64'(core_in_valid), 4'b1000);
        step();
        chk("t4_once", 64'(core_in_valid), 0);
        ext_in_valid = 1'b1; ext_in_core_id = 3'd5; ext_in_data = 32'h55555555;
        step();
        ext_in_valid = 1'b0;
        chk("t4_oob", 64'(core_in_valid), 0);
        step();
        chk("t4_oob2", 64'(core_in_valid), 0);

        // Async reset while holding with buffered entries.
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 3; c++) drive_push(c, 2'd3, 32'hBAD0_0000 | (c << 4) | n);
            step();
        end
        core_out_valid = '0;
        step();
        chk("t5_hold", 64'(ext_out_valid), 1);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_async", {ext_out_valid, ext_out_core_id, ext_out_data, core_out_full}, 0);
        do_reset();
        repeat (3) begin
            step();
            chk("t5_nostale", 64'(ext_out_valid), 0);
        end
        ext_out_ready = 1'b1;
        drive_push(3, 2'd2, 32'h3333_0003);
        drive_push(0, 2'd1, 32'h0000_0A00);
        out_q.push_back('{id: 3'd0, cmd: 2'd1, data: 32'h0000_0A00});
        out_q.push_back('{id: 3'd3, cmd: 2'd2, data: 32'h3333_0003});
        step();
        core_out_valid = '0;
        step();
        chk("t5_first", {ext_out_valid, ext_out_core_id}, {1'b1, 3'd0});
        step();
        chk("t5_second", {ext_out_valid, ext_out_core_id}, {1'b1, 3'd3});
        step();
        chk("t5_idle", 64'(ext_out_valid), 0);

        // Push on a full FIFO in the same cycle it is popped.
        ext_out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            drive_push(2, 2'd0, 32'hB200_0000 + n);
            out_q.push_back('{id: 3'd2, cmd: 2'd0, data: 32'hB200_0000 + n});
            step();
        end
        chk("t6_full", 64'(core_out_full), 4'b0100);
        drive_push(2, 2'd3, 32'hDEAD_0000);
        ext_out_ready = 1'b1;
        step();
        core_out_valid = '0;
        chk("t6_dec", 64'(core_out_full), 0);
        chk("t6_ovf", 64'(core_out_overflow), 4'b0100);
`ifdef PERIPHERAL_HUB_STATS_EN
        chk("t6_drop_cnt", 64'(stat_drop_count[23:16]), 1);
`endif
        repeat (6) step();
        chk("t6_drained", 64'(ext_out_valid), 0);

        step();
        chk("queues_empty", 64'(out_q.size() + in_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
